// File: rtl/onehot_pulse_dec_pkg.sv
// Shared definitions for the one-hot pulse decoder.
//   state_t : FSM encoding (IDLE / DRIVE / GAP)
//   DEC_W   : width of the one-hot strobe vector
//   IDX_W   : width of the index that selects a strobe line
//   CNT_W   : width of the pulse/gap down-counter
package onehot_pulse_dec_pkg;

    localparam int DEC_W = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/onehot_dec_3to8.sv
// Combinational index -> one-hot decoder with an enable gate.
//   idx_i : index to decode (n -> bit n)
//   en_i  : when low the output is all-zero
//   dec_o : one-hot vector (at most one bit high)
module onehot_dec_3to8
    import onehot_pulse_dec_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [DEC_W-1:0] dec_o
);

    genvar gi;
    generate
        for (gi = 0; gi < DEC_W; gi++) begin : g_line
            assign dec_o[gi] = en_i && (idx_i == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/onehot_pulse_dec.sv
// Re-expands an accepted 3-bit index into a PULSE_LEN-cycle one-hot strobe,
// followed by GAP_LEN all-zero cycles before the next index is accepted.
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-high
//   code_in    : index to decode
//   code_valid : code_in valid this cycle
//   code_ready : high only in IDLE; transfer on code_valid && code_ready
//   dec_out    : one-hot strobe during DRIVE, zero otherwise
//   busy       : high in DRIVE or GAP
//   done       : one-cycle pulse on the last DRIVE cycle
// All outputs decode registered state only, so a reset clears them at once.
module onehot_pulse_dec
    import onehot_pulse_dec_pkg::*;
#(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] code_in,
    input  logic             code_valid,
    output logic             code_ready,
    output logic [DEC_W-1:0] dec_out,
    output logic             busy,
    output logic             done
);

    // Counter load values: the counter runs load..0, giving LEN cycles.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam bit               HAS_GAP    = (GAP_LEN > 0);
    localparam logic [CNT_W-1:0] GAP_LOAD   = HAS_GAP ? CNT_W'(GAP_LEN - 1) : '0;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (code_valid) begin
                    state_d = ST_DRIVE;
                    idx_d   = code_in;
                    cnt_d   = PULSE_LOAD;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    if (HAS_GAP) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign code_ready = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_DRIVE) || (state_q == ST_GAP);
    assign done       = (state_q == ST_DRIVE) && (cnt_q == '0);

    onehot_dec_3to8 u_dec (
        .idx_i (idx_q),
        .en_i  (state_q == ST_DRIVE),
        .dec_o (dec_out)
    );

endmodule

// File: tb/tb_onehot_pulse_dec.sv
module tb_onehot_pulse_dec;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] code_in = 3'd0;
    logic       code_valid = 1'b0;
    logic       code_ready;
    logic [7:0] dec_out;
    logic       busy;
    logic       done;

    // Second instance with the edge parameters PULSE_LEN=1, GAP_LEN=0.
    logic [2:0] e_code = 3'd0;
    logic       e_valid = 1'b0;
    logic       e_ready;
    logic [7:0] e_dec;
    logic       e_busy;
    logic       e_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    onehot_pulse_dec #(.PULSE_LEN(4), .GAP_LEN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .dec_out    (dec_out),
        .busy       (busy),
        .done       (done)
    );

    onehot_pulse_dec #(.PULSE_LEN(1), .GAP_LEN(0)) dut_e (
        .clk        (clk),
        .rst        (rst),
        .code_in    (e_code),
        .code_valid (e_valid),
        .code_ready (e_ready),
        .dec_out    (e_dec),
        .busy       (e_busy),
        .done       (e_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (dec_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: dec=%h busy=%b done=%b, required dec=00 busy=0 done=0", dec_out, busy, done);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (code_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: code_ready=%b, required 1", code_ready);
        end
        $display("reset: dec=%h busy=%b done=%b ready=%b", dec_out, busy, done, code_ready);
    endtask

    // Transfer idx, then check 4 DRIVE cycles, 1 GAP cycle and return to IDLE.
    task automatic run_pulse(input logic [2:0] idx, input string name);
        logic [7:0] exp_dec;
        exp_dec = 8'd1 << idx;
        code_in = idx;
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        code_in = 3'd0;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (dec_out !== exp_dec || busy !== 1'b1 || code_ready !== 1'b0 || done !== (k == 4)) begin
                failures++;
                $display("FAIL %s_drive%0d: dec=%h busy=%b ready=%b done=%b, required dec=%h busy=1 ready=0 done=%b",
                         name, k, dec_out, busy, code_ready, done, exp_dec, (k == 4));
            end
            checks++;
            if ($countones(dec_out) > 1) begin
                failures++;
                $display("FAIL %s_multi%0d: dec=%h, required at most one bit", name, k, dec_out);
            end
            step();
        end
        checks++;
        if (dec_out !== 8'h00 || busy !== 1'b1 || code_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s_gap: dec=%h busy=%b ready=%b done=%b, required dec=00 busy=1 ready=0 done=0",
                     name, dec_out, busy, code_ready, done);
        end
        step();
        checks++;
        if (dec_out !== 8'h00 || busy !== 1'b0 || code_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_idle: dec=%h busy=%b ready=%b, required dec=00 busy=0 ready=1",
                     name, dec_out, busy, code_ready);
        end
        $display("%s: idx=%0d strobe=%h", name, idx, exp_dec);
    endtask

    task automatic test_single();
        run_pulse(3'd5, "single");
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 8; i++) begin
            run_pulse(3'(i), "sweep");
        end
    endtask

    task automatic test_ignore();
        int n;
        code_in = 3'd2;
        code_valid = 1'b1;
        step();
        code_in = 3'd7;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (dec_out !== 8'b0000_0100 || code_ready !== 1'b0) begin
                failures++;
                $display("FAIL ignore_drive%0d: dec=%h ready=%b, required dec=04 ready=0", k, dec_out, code_ready);
            end
            step();
        end
        checks++;
        if (dec_out !== 8'h00 || code_ready !== 1'b0) begin
            failures++;
            $display("FAIL ignore_gap: dec=%h ready=%b, required dec=00 ready=0", dec_out, code_ready);
        end
        step();
        checks++;
        if (code_ready !== 1'b1 || dec_out !== 8'h00) begin
            failures++;
            $display("FAIL ignore_idle: ready=%b dec=%h, required ready=1 dec=00", code_ready, dec_out);
        end
        step();
        code_valid = 1'b0;
        checks++;
        if (dec_out !== 8'h80) begin
            failures++;
            $display("FAIL ignore_next: dec=%h, required 80", dec_out);
        end
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
        $display("ignore: first=04 second=80 drained in %0d cycles", n);
    endtask

    task automatic test_edge_params();
        e_code = 3'd0;
        e_valid = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (e_dec !== ((k % 2 == 0) ? 8'h01 : 8'h00) || e_done !== (k % 2 == 0)) begin
                failures++;
                $display("FAIL edge_cycle%0d: dec=%h done=%b, required dec=%h done=%b",
                         k, e_dec, e_done, ((k % 2 == 0) ? 8'h01 : 8'h00), (k % 2 == 0));
            end
            step();
        end
        e_valid = 1'b0;
        step();
        step();
        checks++;
        if (e_dec !== 8'h00 || e_busy !== 1'b0 || e_ready !== 1'b1) begin
            failures++;
            $display("FAIL edge_idle: dec=%h busy=%b ready=%b, required dec=00 busy=0 ready=1", e_dec, e_busy, e_ready);
        end
        $display("edge_params: alternating 01/00 with done on strobe");
    endtask

    task automatic test_reset_mid_pulse();
        code_in = 3'd3;
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        checks++;
        if (dec_out !== 8'h08) begin
            failures++;
            $display("FAIL midrst_c1: dec=%h, required 08", dec_out);
        end
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dec_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: dec=%h busy=%b done=%b, required dec=00 busy=0 done=0", dec_out, busy, done);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (dec_out !== 8'h00 || busy !== 1'b0 || code_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_idle: dec=%h busy=%b ready=%b, required dec=00 busy=0 ready=1", dec_out, busy, code_ready);
        end
        $display("reset_mid_pulse: dec=%h busy=%b ready=%b", dec_out, busy, code_ready);
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        test_reset();
        test_single();
        test_sweep();
        test_ignore();
        test_edge_params();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
